pacman_controller: RTL

Control FSM that sequences the Pacman `datapath` through one game tick: draw sprite, wait on the tick timer, erase sprite, latch joystick direction, move one step, repeat. It drives every `en_*`/`s_*` select of the datapath, plus a per-pixel plot strobe and sprite pixel offsets. The top level adds those offsets to `x_plot`/`y_plot` before the VGA adapter write port.

---
 rtl/pacman_pkg.sv | 26 ++
 rtl/pacman_controller_if.sv | 39 +++
 rtl/sprite_scan.sv | 44 ++++
 rtl/pacman_controller.sv | 118 +++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and select encodings for the Pacman controller and datapath.
package pacman_pkg;

    typedef enum logic [2:0] {IDLE, INIT, DRAW, WAIT, ERASE, TURN, MOVE} ctrl_state_t;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [1:0] SEL_POS_LOAD  = 2'd0;
    localparam logic [1:0] SEL_POS_INC   = 2'd1;
    localparam logic [1:0] SEL_POS_DEC   = 2'd2;
    localparam logic [1:0] SEL_DIR_START = 2'd0;
    localparam logic [1:0] SEL_DIR_INPUT = 2'd1;
    localparam logic [1:0] SEL_TMR_LOAD  = 2'd0;
    localparam logic [1:0] SEL_TMR_COUNT = 2'd1;
    localparam logic [1:0] COLOR_BG      = 2'd0;
    localparam logic [1:0] COLOR_PACMAN  = 2'd1;

    // Offset counter width; a 1-pixel dimension still needs a 1-bit port.
    function automatic int unsigned off_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pacman_controller_if.sv
// Control/status bundle between the Pacman controller (master) and datapath (slave).
interface pacman_controller_if import pacman_pkg::*; #(
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4
);
    localparam int unsigned XW = off_width(SPRITE_W);
    localparam int unsigned YW = off_width(SPRITE_H);

    logic          timer_done;
    logic [1:0]    cur_direction;
    logic          blocked;
    logic          en_x_position;
    logic          en_y_position;
    logic          en_direction;
    logic          en_timer;
    logic [1:0]    s_x_position;
    logic [1:0]    s_y_position;
    logic [1:0]    s_direction;
    logic [1:0]    s_timer;
    logic [1:0]    s_plot_color;
    logic          plot;
    logic [XW-1:0] x_off;
    logic [YW-1:0] y_off;

    modport master (
        input  timer_done, cur_direction, blocked,
        output en_x_position, en_y_position, en_direction, en_timer,
        output s_x_position, s_y_position, s_direction, s_timer, s_plot_color,
        output plot, x_off, y_off
    );

    modport slave (
        output timer_done, cur_direction, blocked,
        input  en_x_position, en_y_position, en_direction, en_timer,
        input  s_x_position, s_y_position, s_direction, s_timer, s_plot_color,
        input  plot, x_off, y_off
    );

endinterface

// File: rtl/sprite_scan.sv
// Row-major W x H pixel counter shared by the DRAW and ERASE scans.
module sprite_scan import pacman_pkg::*; #(
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4,
    localparam int unsigned XW = off_width(SPRITE_W),
    localparam int unsigned YW = off_width(SPRITE_H)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_start,
    input  logic          i_clear,
    output logic [XW-1:0] o_x_off,
    output logic [YW-1:0] o_y_off,
    output logic          o_last
);
    localparam logic [XW-1:0] XMax = XW'(SPRITE_W - 1);
    localparam logic [YW-1:0] YMax = YW'(SPRITE_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    assign o_x_off = r_x;
    assign o_y_off = r_y;
    assign o_last  = (r_x == XMax) && (r_y == YMax);

    // Wrapping on the last pixel leaves the counters at 0 for the next scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_start) begin
            if (r_x == XMax) begin
                r_x <= '0;
                r_y <= (r_y == YMax) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pacman_controller.sv
// Game-tick sequencer: draw, wait for timer, erase, latch direction, move one step.
module pacman_controller import pacman_pkg::*; #(
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                startGame,
    pacman_controller_if.master bus
);
    localparam int unsigned XW = off_width(SPRITE_W);
    localparam int unsigned YW = off_width(SPRITE_H);

    ctrl_state_t   r_state;
    logic          w_restart;
    logic          w_scan;
    logic          w_last;
    logic [XW-1:0] w_x_off;
    logic [YW-1:0] w_y_off;

    assign w_restart = startGame && (r_state != IDLE) && (r_state != INIT);
    assign w_scan    = (r_state == DRAW) || (r_state == ERASE);

    sprite_scan #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_scan),
        .i_clear (w_restart),
        .o_x_off (w_x_off),
        .o_y_off (w_y_off),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else if (w_restart) begin
            r_state <= INIT;
        end else begin
            case (r_state)
                IDLE:    if (startGame) r_state <= INIT;
                INIT:    if (!startGame) r_state <= DRAW;
                DRAW:    if (w_last) r_state <= WAIT;
                WAIT:    if (bus.timer_done) r_state <= ERASE;
                ERASE:   if (w_last) r_state <= TURN;
                TURN:    r_state <= MOVE;
                MOVE:    r_state <= DRAW;
                default: r_state <= IDLE;
            endcase
        end
    end

    // MOVE reads cur_direction/blocked after TURN has latched the new direction.
    always_comb begin
        bus.en_x_position = 1'b0;
        bus.en_y_position = 1'b0;
        bus.en_direction  = 1'b0;
        bus.en_timer      = 1'b0;
        bus.s_x_position  = SEL_POS_LOAD;
        bus.s_y_position  = SEL_POS_LOAD;
        bus.s_direction   = SEL_DIR_START;
        bus.s_timer       = SEL_TMR_LOAD;
        bus.s_plot_color  = COLOR_BG;
        bus.plot          = 1'b0;
        case (r_state)
            INIT: begin
                bus.en_x_position = 1'b1;
                bus.en_y_position = 1'b1;
                bus.en_direction  = 1'b1;
                bus.en_timer      = 1'b1;
            end
            DRAW: begin
                bus.plot         = 1'b1;
                bus.s_plot_color = COLOR_PACMAN;
                bus.en_timer     = w_last;
            end
            WAIT: begin
                bus.en_timer = 1'b1;
                bus.s_timer  = SEL_TMR_COUNT;
            end
            ERASE: bus.plot = 1'b1;
            TURN: begin
                bus.en_direction = 1'b1;
                bus.s_direction  = SEL_DIR_INPUT;
            end
            MOVE: begin
                if (!bus.blocked) begin
                    unique case (bus.cur_direction)
                        DIR_RIGHT: begin
                            bus.en_x_position = 1'b1;
                            bus.s_x_position  = SEL_POS_INC;
                        end
                        DIR_LEFT: begin
                            bus.en_x_position = 1'b1;
                            bus.s_x_position  = SEL_POS_DEC;
                        end
                        DIR_UP: begin
                            bus.en_y_position = 1'b1;
                            bus.s_y_position  = SEL_POS_DEC;
                        end
                        DIR_DOWN: begin
                            bus.en_y_position = 1'b1;
                            bus.s_y_position  = SEL_POS_INC;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign bus.x_off = w_x_off;
    assign bus.y_off = w_y_off;

endmodule
